// File: rtl/fft_uart_sequencer.sv
// fft_uart_sequencer
// Frame controller between a UART byte link and a pipeline FFT core.
// Receives 2*N little-endian bytes and streams them into the FFT as N real
// samples. It then buffers the N complex results and returns them to the UART
// transmitter, 4 bytes per bin (re lo, re hi, im lo, im hi).
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   rx_valid, rx_data               received byte strobe / byte
//   fft_start                       pulse with the first sample of a frame
//   fft_in_valid, fft_in_re/_im     sample strobe / {hi,lo} sample / zero
//   fft_out_valid, fft_out_re/_im   FFT result strobe / components
//   tx_valid, tx_data, tx_ready     byte handshake towards the UART tx
//   busy                            not idle
//   frame_done                      pulse after the last tx byte is accepted
//   err_timeout, err_overrun        sticky error flags, cleared by reset only
module fft_uart_sequencer #(
  parameter int N       = 256,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          fft_start,
  output logic          fft_in_valid,
  output logic [DW-1:0] fft_in_re,
  output logic [DW-1:0] fft_in_im,
  input  logic          fft_out_valid,
  input  logic [DW-1:0] fft_out_re,
  input  logic [DW-1:0] fft_out_im,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 2;
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(N - 1);
  localparam logic [CW-1:0] LAST_BYTE   = CW'(4 * N - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_SEND} state_t;
  state_t state, state_nxt;

  logic [7:0]      lo_byte;
  logic            have_lo;
  logic [CW-1:0]   sample_cnt;
  logic [CW-1:0]   res_cnt;
  logic [CW-1:0]   tx_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [2*DW-1:0] ram [N];
  logic [2*DW-1:0] rd_word;

  logic rx_lo, rx_hi, last_sample, gap_expire;
  logic res_wr, last_res, tx_acc, last_tx, overrun;

  // A byte is a lo byte when it opens a frame or follows a completed sample.
  assign rx_lo       = rx_valid && ((state == S_IDLE) || (state == S_LOAD && !have_lo));
  assign rx_hi       = rx_valid && (state == S_LOAD) && have_lo;
  assign last_sample = rx_hi && (sample_cnt == LAST_SAMPLE);
  // Fires on the TIMEOUT-th consecutive idle cycle after the last rx byte.
  assign gap_expire  = (state == S_LOAD) && !rx_valid && (gap_cnt == GAP_LAST);
  assign res_wr      = (state == S_WAIT) && fft_out_valid;
  assign last_res    = res_wr && (res_cnt == LAST_SAMPLE);
  assign tx_acc      = (state == S_SEND) && tx_ready;
  assign last_tx     = tx_acc && (tx_cnt == LAST_BYTE);
  // Includes the final SEND cycle, where the FSM is leaving for IDLE.
  assign overrun     = rx_valid && ((state == S_WAIT) || (state == S_SEND));

  assign fft_in_im = '0;
  assign rd_word   = ram[tx_cnt[CW-1:2]];

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (rx_valid)    state_nxt = S_LOAD;
      S_LOAD: if (gap_expire)  state_nxt = S_IDLE;
              else if (last_sample) state_nxt = S_WAIT;
      S_WAIT: if (last_res)    state_nxt = S_SEND;
      S_SEND: if (last_tx)     state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    tx_valid = (state == S_SEND);
    tx_data  = '0;
    if (state == S_SEND) begin
      unique case (tx_cnt[1:0])
        2'd0: tx_data = rd_word[DW+7:DW];
        2'd1: tx_data = rd_word[2*DW-1:DW+8];
        2'd2: tx_data = rd_word[7:0];
        default: tx_data = rd_word[DW-1:8];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lo_byte      <= '0;
      have_lo      <= 1'b0;
      sample_cnt   <= '0;
      res_cnt      <= '0;
      tx_cnt       <= '0;
      gap_cnt      <= '0;
      fft_in_valid <= 1'b0;
      fft_start    <= 1'b0;
      fft_in_re    <= '0;
      frame_done   <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state        <= state_nxt;
      fft_in_valid <= rx_hi;
      fft_start    <= rx_hi && (sample_cnt == '0);
      fft_in_re    <= rx_hi ? {rx_data, lo_byte} : '0;
      frame_done   <= last_tx;
      if (gap_expire) err_timeout <= 1'b1;
      if (overrun)    err_overrun <= 1'b1;

      if (rx_lo) lo_byte <= rx_data;

      if (state == S_LOAD && !rx_valid) gap_cnt <= gap_cnt + GW'(1);
      else                              gap_cnt <= '0;

      // Leaving for IDLE (or sitting in it) keeps every frame counter at 0.
      if (state_nxt == S_IDLE) begin
        have_lo    <= 1'b0;
        sample_cnt <= '0;
        res_cnt    <= '0;
        tx_cnt     <= '0;
      end else begin
        if (rx_lo)       have_lo <= 1'b1;
        else if (rx_hi)  have_lo <= 1'b0;
        if (rx_hi)  sample_cnt <= sample_cnt + CW'(1);
        if (res_wr) res_cnt    <= res_cnt + CW'(1);
        if (tx_acc) tx_cnt     <= tx_cnt + CW'(1);
      end
    end
  end

  // Result buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (res_wr) ram[res_cnt[AW-1:0]] <= {fft_out_re, fft_out_im};
  end

endmodule

// File: tb/tb_fft_uart_sequencer.sv
module tb_fft_uart_sequencer;
  localparam int N       = 256;
  localparam int DW      = 16;
  localparam int TIMEOUT = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          fft_start, fft_in_valid;
  logic [DW-1:0] fft_in_re, fft_in_im;
  logic          fft_out_valid;
  logic [DW-1:0] fft_out_re, fft_out_im;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          busy, frame_done, err_timeout, err_overrun;

  fft_uart_sequencer #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .fft_start(fft_start), .fft_in_valid(fft_in_valid),
    .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
    .fft_out_valid(fft_out_valid), .fft_out_re(fft_out_re), .fft_out_im(fft_out_im),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  lo, hi;
    logic [15:0] exp_in;
    logic [15:0] re, im;
    logic [31:0] exp_bytes;   // tx bytes in send order, first byte in [31:24]
  } vec_t;

  vec_t        tbl [6];
  int          checks = 0, errors = 0;
  logic [7:0]  rx_bytes [2*N];
  logic [15:0] res_re [N], res_im [N];
  logic [15:0] in_q [$];
  int          start_pos [$];
  logic [7:0]  tx_q [$];
  int          im_bad = 0, done_cnt = 0;
  bit          rand_ready = 0;
  bit          hold = 0;
  logic [7:0]  hold_data = '0;

  // Monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (fft_in_valid) begin
      if (fft_start) start_pos.push_back(in_q.size());
      if (fft_in_im !== '0) im_bad++;
      in_q.push_back(fft_in_re);
    end else if (fft_start) begin
      start_pos.push_back(-1);
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (frame_done) done_cnt++;
    if (hold && tx_valid && rst_n) begin
      checks++;
      if (tx_data !== hold_data) begin
        errors++;
        $display("FAIL tx_stable act=%0h req=%0h", tx_data, hold_data);
      end
    end
    hold      = tx_valid && !tx_ready;
    hold_data = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tx_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic clear_mon();
    in_q.delete(); start_pos.delete(); tx_q.delete();
    im_bad = 0; done_cnt = 0;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 2*N; i++) rx_bytes[i] = 8'(i >> 1);
    for (int k = 0; k < N; k++) begin
      res_re[k] = 16'(k);
      res_im[k] = 16'(-k);
    end
  endtask

  task automatic send_bytes(input int nb);
    for (int i = 0; i < nb; i++) begin
      rx_valid = 1'b1;
      rx_data  = rx_bytes[i];
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_in(input int n);
    int t = 0;
    while (in_q.size() < n && t < 100) begin tick(); t++; end
    chk("in_wait_bound", 64'(in_q.size() >= n), 64'd1);
  endtask

  task automatic feed_results();
    for (int k = 0; k < N; k++) begin
      fft_out_valid = 1'b1;
      fft_out_re    = res_re[k];
      fft_out_im    = res_im[k];
      tick();
    end
    fft_out_valid = 1'b0;
  endtask

  task automatic collect(input int stop_at);
    int t = 0;
    while (done_cnt == 0 && tx_q.size() < stop_at && t < 20000) begin tick(); t++; end
    chk("tx_wait_bound", 64'(t < 20000), 64'd1);
  endtask

  task automatic check_frame(input string nm);
    int bad = 0;
    logic [7:0] eb;
    chk({nm, "_in_cnt"}, 64'(in_q.size()), 64'(N));
    for (int i = 0; i < in_q.size() && i < N; i++)
      if (in_q[i] !== {rx_bytes[2*i+1], rx_bytes[2*i]}) bad++;
    chk({nm, "_in_bad"}, 64'(bad), 64'd0);
    chk({nm, "_im_bad"}, 64'(im_bad), 64'd0);
    chk({nm, "_start_cnt"}, 64'(start_pos.size()), 64'd1);
    if (start_pos.size() > 0) chk({nm, "_start_pos"}, 64'(start_pos[0]), 64'd0);
    chk({nm, "_tx_cnt"}, 64'(tx_q.size()), 64'(4*N));
    bad = 0;
    for (int j = 0; j < tx_q.size() && j < 4*N; j++) begin
      case (j % 4)
        0: eb = res_re[j/4][7:0];
        1: eb = res_re[j/4][15:8];
        2: eb = res_im[j/4][7:0];
        default: eb = res_im[j/4][15:8];
      endcase
      if (tx_q[j] !== eb) bad++;
    end
    chk({nm, "_tx_bad"}, 64'(bad), 64'd0);
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input string nm);
    clear_mon();
    send_bytes(2*N);
    wait_in(N);
    repeat (2) tick();
    feed_results();
    collect(4*N);
    repeat (2) tick();
    check_frame(nm);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({fft_start, fft_in_valid, fft_in_re, fft_in_im, tx_valid, tx_data,
                busy, frame_done, err_timeout, err_overrun});
  endfunction

  initial begin
    tbl[0] = '{8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 32'h00000000};
    tbl[1] = '{8'h34, 8'h12, 16'h1234, 16'h0001, 16'hFFFF, 32'h0100FFFF};
    tbl[2] = '{8'hFF, 8'h7F, 16'h7FFF, 16'h8000, 16'h7FFF, 32'h0080FF7F};
    tbl[3] = '{8'h00, 8'h80, 16'h8000, 16'hABCD, 16'h1234, 32'hCDAB3412};
    tbl[4] = '{8'hFF, 8'hFF, 16'hFFFF, 16'h00FF, 16'hFF00, 32'hFF0000FF};
    tbl[5] = '{8'h01, 8'h00, 16'h0001, 16'hFFFF, 16'h0000, 32'hFFFF0000};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    fft_out_valid = 1'b0; fft_out_re = '0; fft_out_im = '0;
    repeat (3) tick();
    chk("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_outs", all_outs(), 64'd0);

    // Ramp frame with an always-ready transmitter.
    fill_default();
    run_frame("ramp");
    if (in_q.size() == N) begin
      chk("ramp_s1", 64'(in_q[1]), 64'h0101);
      chk("ramp_s255", 64'(in_q[255]), 64'hFFFF);
    end
    if (tx_q.size() >= 8)
      chk("ramp_bin1", 64'({tx_q[4], tx_q[5], tx_q[6], tx_q[7]}), 64'h0100FFFF);

    // Table frame with a stalling transmitter.
    fill_default();
    for (int i = 0; i < 6; i++) begin
      rx_bytes[2*i]   = tbl[i].lo;
      rx_bytes[2*i+1] = tbl[i].hi;
      res_re[i]       = tbl[i].re;
      res_im[i]       = tbl[i].im;
    end
    rand_ready = 1;
    run_frame("table");
    rand_ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_q.size() > i) chk($sformatf("tbl_in%0d", i), 64'(in_q[i]), 64'(tbl[i].exp_in));
      if (tx_q.size() > 4*i+3)
        chk($sformatf("tbl_tx%0d", i),
            64'({tx_q[4*i], tx_q[4*i+1], tx_q[4*i+2], tx_q[4*i+3]}), 64'(tbl[i].exp_bytes));
    end

    // Inter-byte timeout after 101 bytes: exact-boundary check.
    fill_default();
    clear_mon();
    send_bytes(101);
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet", 64'(err_timeout), 64'd0);
    chk("to_busy_before", 64'(busy), 64'd1);
    tick();
    chk("to_flag", 64'(err_timeout), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("to_samples", 64'(in_q.size()), 64'd50);
    chk("to_sticky", 64'(err_timeout), 64'd1);
    run_frame("after_to");

    // Overrun: three bytes during WAIT must not disturb the frame.
    clear_mon();
    send_bytes(2*N);
    wait_in(N);
    tick();
    chk("ovr_before", 64'(err_overrun), 64'd0);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'hA5; tick();
    end
    rx_valid = 1'b0;
    tick();
    chk("ovr_flag", 64'(err_overrun), 64'd1);
    feed_results();
    collect(4*N);
    repeat (2) tick();
    check_frame("ovr");

    // Reset pulse at tx byte 300 of SEND.
    clear_mon();
    send_bytes(2*N);
    wait_in(N);
    repeat (2) tick();
    feed_results();
    collect(300);
    chk("mid_tx_cnt", 64'(tx_q.size()), 64'd300);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_outs", all_outs(), 64'd0);
    tick();
    chk("mid_post_outs", all_outs(), 64'd0);
    run_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
